// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file with N_WRITE write ports and
// N_READ read ports. Highest-index write port wins on address collisions,
// out-of-range writes are dropped and out-of-range reads return zero.
// Optional write->read bypass (write-first) and optional registered reads.
//
// Read handshake: read_valid[j] qualifies read_data[j]. With READ_LATENCY=1 a
// read issued with read_en[j]=1 on an edge produces read_valid[j]=1 for the
// following cycle; with read_en[j]=0 the data holds and the valid drops. With
// READ_LATENCY=0 read_valid[j] is simply "out of reset" and read_en is ignored.
module regfile_multiport #(
   parameter int               WIDTH        = 4,
   parameter int               DEPTH        = 4,
   parameter int               ADDR_W       = $clog2(DEPTH),
   parameter int               N_WRITE      = 2,
   parameter int               N_READ       = 2,
   parameter int               READ_LATENCY = 1,
   parameter int               BYPASS       = 1,
   parameter logic [WIDTH-1:0] INIT         = '0
) (
   input  logic                       CLK,
   input  logic                       ASYNCRESETN,
   input  logic [N_WRITE-1:0]         write_en,
   input  logic [N_WRITE*ADDR_W-1:0]  write_addr,
   input  logic [N_WRITE*WIDTH-1:0]   write_data,
   input  logic [N_READ-1:0]          read_en,
   input  logic [N_READ*ADDR_W-1:0]   read_addr,
   output logic [N_READ*WIDTH-1:0]    read_data,
   output logic [N_READ-1:0]          read_valid
);

   // Storage and its next-cycle image (the image doubles as the bypass source).
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Value each read port would see this cycle without a read register.
   logic [N_READ-1:0][WIDTH-1:0] rd_comb;

   // Registered read path.
   logic [N_READ-1:0][WIDTH-1:0] rd_data_q;
   logic [N_READ-1:0][WIDTH-1:0] rd_data_d;
   logic [N_READ-1:0]            rd_valid_q;
   logic [N_READ-1:0]            rd_valid_d;

   // Merge enabled writes in ascending port order so the highest port wins.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      for (int k = 0; k < N_WRITE; k++) begin
         if (write_en[k] && (32'(write_addr[k*ADDR_W +: ADDR_W]) < DEPTH)) begin
            mem_d[write_addr[k*ADDR_W +: ADDR_W]] = write_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Storage register; reset loads INIT into every entry.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INIT;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Combinational read: write-first sees the merged image, read-first the old one.
   always_comb begin
      for (int j = 0; j < N_READ; j++) begin
         rd_comb[j] = '0;
         if (32'(read_addr[j*ADDR_W +: ADDR_W]) < DEPTH) begin
            if (BYPASS != 0) begin
               rd_comb[j] = mem_d[read_addr[j*ADDR_W +: ADDR_W]];
            end else begin
               rd_comb[j] = mem_q[read_addr[j*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   // Read register next state: capture on read_en, otherwise hold data and drop valid.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      for (int j = 0; j < N_READ; j++) begin
         if (read_en[j]) begin
            rd_data_d[j]  = rd_comb[j];
            rd_valid_d[j] = 1'b1;
         end
      end
   end

   // Read register; cleared by reset.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         rd_data_q  <= '0;
         rd_valid_q <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_comb_read
         assign read_data  = rd_comb;
         assign read_valid = {N_READ{ASYNCRESETN}};
      end else begin : g_reg_read
         assign read_data  = rd_data_q;
         assign read_valid = rd_valid_q;
      end
   endgenerate

endmodule
